// File: rtl/map_table.sv
// Register rename map table: architectural-to-physical tag map with per-entry ready bits.
// Define MAP_TABLE_CDB_BYPASS_EN to forward same-cycle CDB broadcasts onto the ready outputs.
module map_table #(
  parameter int NUM_AR = 32,
  parameter int NUM_PR = 64,
  parameter int AW     = $clog2(NUM_AR),
  parameter int PW     = $clog2(NUM_PR)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 dispatch_en,
  input  logic [AW-1:0]        dest_idx,
  input  logic [PW-1:0]        T_in,
  input  logic [AW-1:0]        rs1_idx,
  input  logic [AW-1:0]        rs2_idx,
  input  logic                 cdb_en,
  input  logic [PW-1:0]        cdb_T,
  input  logic                 rollback_en,
  input  logic [NUM_AR*PW-1:0] rollback_map,
  output logic [PW-1:0]        T_old_out,
  output logic [PW-1:0]        T1_out,
  output logic [PW-1:0]        T2_out,
  output logic                 T1_ready,
  output logic                 T2_ready
);

  localparam int ZERO_REG = NUM_AR - 1;

  logic [PW-1:0] cur_tag [NUM_AR];
  logic          cur_rdy [NUM_AR];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_AR; gi++) begin : g_entry
      if (gi == ZERO_REG) begin : g_zero
        // The zero register is pinned to its own tag and always ready.
        assign cur_tag[gi] = PW'(gi);
        assign cur_rdy[gi] = 1'b1;
      end else begin : g_live
        logic [PW-1:0] tag_q, tag_d;
        logic          rdy_q, rdy_d;

        always_comb begin
          tag_d = tag_q;
          rdy_d = rdy_q;
          if (en) begin
            if (rollback_en) begin
              tag_d = rollback_map[gi*PW +: PW];
              rdy_d = 1'b1;
            end else begin
              if (cdb_en && (tag_q == cdb_T)) begin
                rdy_d = 1'b1;
              end
              // A rename lands after the CDB so it wins on the same entry.
              if (dispatch_en && (dest_idx == AW'(gi))) begin
                tag_d = T_in;
                rdy_d = 1'b0;
              end
            end
          end
        end

        always_ff @(posedge clock) begin
          if (!reset) begin
            tag_q <= PW'(gi);
            rdy_q <= 1'b1;
          end else begin
            tag_q <= tag_d;
            rdy_q <= rdy_d;
          end
        end

        assign cur_tag[gi] = tag_q;
        assign cur_rdy[gi] = rdy_q;
      end
    end
  endgenerate

  // The committed map slot of the zero register is never loaded.
  logic unused_rb;
  assign unused_rb = ^rollback_map[ZERO_REG*PW +: PW];

  assign T_old_out = cur_tag[dest_idx];
  assign T1_out    = cur_tag[rs1_idx];
  assign T2_out    = cur_tag[rs2_idx];

`ifdef MAP_TABLE_CDB_BYPASS_EN
  assign T1_ready = cur_rdy[rs1_idx] | (cdb_en && (cdb_T == cur_tag[rs1_idx]));
  assign T2_ready = cur_rdy[rs2_idx] | (cdb_en && (cdb_T == cur_tag[rs2_idx]));
`else
  assign T1_ready = cur_rdy[rs1_idx];
  assign T2_ready = cur_rdy[rs2_idx];
`endif

endmodule

// File: tb/tb_map_table.sv
// Self-checking bench for map_table: directed scenarios then random traffic against a reference map.
module tb_map_table;
  localparam int NUM_AR = 32;
  localparam int NUM_PR = 64;
  localparam int AW     = 5;
  localparam int PW     = 6;

  logic                 clock = 1'b0;
  logic                 reset;
  logic                 en;
  logic                 dispatch_en;
  logic [AW-1:0]        dest_idx;
  logic [PW-1:0]        T_in;
  logic [AW-1:0]        rs1_idx;
  logic [AW-1:0]        rs2_idx;
  logic                 cdb_en;
  logic [PW-1:0]        cdb_T;
  logic                 rollback_en;
  logic [NUM_AR*PW-1:0] rollback_map;
  logic [PW-1:0]        T_old_out;
  logic [PW-1:0]        T1_out;
  logic [PW-1:0]        T2_out;
  logic                 T1_ready;
  logic                 T2_ready;

  always #5 clock = ~clock;

  map_table #(.NUM_AR(NUM_AR), .NUM_PR(NUM_PR)) dut (
    .clock(clock), .reset(reset), .en(en), .dispatch_en(dispatch_en),
    .dest_idx(dest_idx), .T_in(T_in), .rs1_idx(rs1_idx), .rs2_idx(rs2_idx),
    .cdb_en(cdb_en), .cdb_T(cdb_T), .rollback_en(rollback_en),
    .rollback_map(rollback_map), .T_old_out(T_old_out), .T1_out(T1_out),
    .T2_out(T2_out), .T1_ready(T1_ready), .T2_ready(T2_ready)
  );

  // Reference: architectural register -> (physical tag, ready)
  int m_tag [NUM_AR];
  bit m_rdy [NUM_AR];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_identity();
    for (int i = 0; i < NUM_AR; i++) begin
      m_tag[i] = i;
      m_rdy[i] = 1'b1;
    end
  endtask

  task automatic model_step();
    if (!reset) begin
      model_identity();
    end else if (en) begin
      if (rollback_en) begin
        for (int i = 0; i < NUM_AR - 1; i++) begin
          m_tag[i] = int'(rollback_map[i*PW +: PW]);
          m_rdy[i] = 1'b1;
        end
      end else begin
        if (cdb_en)
          for (int i = 0; i < NUM_AR; i++)
            if (m_tag[i] == int'(cdb_T)) m_rdy[i] = 1'b1;
        if (dispatch_en && dest_idx != 5'd31) begin
          m_tag[dest_idx] = int'(T_in);
          m_rdy[dest_idx] = 1'b0;
        end
      end
    end
  endtask

  function automatic bit exp_ready(input int idx);
    bit r;
    r = m_rdy[idx];
`ifdef MAP_TABLE_CDB_BYPASS_EN
    if (cdb_en && int'(cdb_T) == m_tag[idx]) r = 1'b1;
`endif
    return r;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".T_old"}, 32'(T_old_out), 32'(m_tag[dest_idx]));
    chk({tag, ".T1"},    32'(T1_out),    32'(m_tag[rs1_idx]));
    chk({tag, ".T2"},    32'(T2_out),    32'(m_tag[rs2_idx]));
    chk({tag, ".T1rdy"}, 32'(T1_ready),  32'(exp_ready(rs1_idx)));
    chk({tag, ".T2rdy"}, 32'(T2_ready),  32'(exp_ready(rs2_idx)));
    $display("step %s dest=%0d rs1=%0d rs2=%0d T_old=%0d T1=%0d/%0b T2=%0d/%0b",
             tag, dest_idx, rs1_idx, rs2_idx, T_old_out, T1_out, T1_ready, T2_out, T2_ready);
  endtask

  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b0; en = 1'b0; dispatch_en = 1'b0; dest_idx = '0; T_in = '0;
    rs1_idx = '0; rs2_idx = '0; cdb_en = 1'b0; cdb_T = '0; rollback_en = 1'b0;
    rollback_map = '0;
    model_identity();
    tick();
    tick();
    reset = 1'b1; en = 1'b1;

    // Identity map after reset
    rs1_idx = 5'd3; rs2_idx = 5'd7; dest_idx = 5'd5;
    #1;
    check_all("reset");
    chk("reset.T1c", 32'(T1_out), 32'd3);
    chk("reset.T2c", 32'(T2_out), 32'd7);
    chk("reset.Toldc", 32'(T_old_out), 32'd5);
    chk("reset.rdyc", 32'({T1_ready, T2_ready}), 32'd3);

    // Back-to-back renames of r1
    dispatch_en = 1'b1; dest_idx = 5'd1; T_in = 6'd33; rs1_idx = 5'd1;
    #1;
    chk("ren1.T_old", 32'(T_old_out), 32'd1);
    chk("ren1.T1pre", 32'(T1_out), 32'd1);
    tick();
    T_in = 6'd34;
    #1;
    chk("ren2.T_old", 32'(T_old_out), 32'd33);
    tick();
    dispatch_en = 1'b0;
    #1;
    chk("ren2.T1", 32'(T1_out), 32'd34);
    chk("ren2.T1rdy", 32'(T1_ready), 32'd0);
    check_all("ren2");

    // CDB wakeup of r2 -> 35
    dispatch_en = 1'b1; dest_idx = 5'd2; T_in = 6'd35;
    tick();
    dispatch_en = 1'b0; rs1_idx = 5'd2; cdb_en = 1'b1; cdb_T = 6'd35;
    #1;
`ifdef MAP_TABLE_CDB_BYPASS_EN
    chk("cdb.same", 32'(T1_ready), 32'd1);
`else
    chk("cdb.same", 32'(T1_ready), 32'd0);
`endif
    tick();
    cdb_en = 1'b0;
    #1;
    chk("cdb.next", 32'(T1_ready), 32'd1);

    // Rename beats a same-cycle CDB on the same entry
    dispatch_en = 1'b1; dest_idx = 5'd4; T_in = 6'd36; cdb_en = 1'b1; cdb_T = 6'd36;
    tick();
    dispatch_en = 1'b0; cdb_en = 1'b0; rs1_idx = 5'd4;
    #1;
    chk("race.T1", 32'(T1_out), 32'd36);
    chk("race.T1rdy", 32'(T1_ready), 32'd0);

    // Zero register is immutable
    dispatch_en = 1'b1; dest_idx = 5'd31; T_in = 6'd40;
    #1;
    chk("zero.T_old", 32'(T_old_out), 32'd31);
    tick();
    dispatch_en = 1'b0; rs1_idx = 5'd31;
    #1;
    chk("zero.T1", 32'(T1_out), 32'd31);
    chk("zero.T1rdy", 32'(T1_ready), 32'd1);

    // Rollback overrides a simultaneous dispatch
    for (int i = 0; i < NUM_AR; i++)
      rollback_map[i*PW +: PW] = (i < 31) ? PW'(i + 32) : PW'(31);
    rollback_en = 1'b1; dispatch_en = 1'b1; dest_idx = 5'd6; T_in = 6'd45;
    tick();
    rollback_en = 1'b0; dispatch_en = 1'b0;
    for (int i = 0; i < NUM_AR; i += 3) begin
      rs1_idx = AW'(i); rs2_idx = AW'((i + 1) % NUM_AR); dest_idx = 5'd6;
      #1;
      chk("rb.T1", 32'(T1_out), (i < 31) ? 32'(i + 32) : 32'd31);
      chk("rb.T1rdy", 32'(T1_ready), 32'd1);
      chk("rb.T_old6", 32'(T_old_out), 32'd38);
    end
    rs1_idx = 5'd31; rs2_idx = 5'd30;
    #1;
    check_all("rb");

    // Global enable freezes state
    en = 1'b0; dispatch_en = 1'b1; dest_idx = 5'd8; T_in = 6'd50;
    tick();
    dispatch_en = 1'b0; en = 1'b1; rs1_idx = 5'd8;
    #1;
    chk("en0.T1", 32'(T1_out), 32'd40);
    chk("en0.T1rdy", 32'(T1_ready), 32'd1);

    // Reset wins over en=0 and pending requests
    en = 1'b0; reset = 1'b0; dispatch_en = 1'b1; rollback_en = 1'b1; cdb_en = 1'b1;
    tick();
    reset = 1'b1; en = 1'b1; dispatch_en = 1'b0; rollback_en = 1'b0; cdb_en = 1'b0;
    rs1_idx = 5'd8; rs2_idx = 5'd2; dest_idx = 5'd1;
    #1;
    chk("rst2.T1", 32'(T1_out), 32'd8);
    chk("rst2.T2", 32'(T2_out), 32'd2);
    chk("rst2.T_old", 32'(T_old_out), 32'd1);
    check_all("rst2");

    // Random traffic against the reference map
    for (int n = 0; n < 400; n++) begin
      reset       = ($urandom_range(0, 99) != 0);
      en          = ($urandom_range(0, 9) != 0);
      dispatch_en = $urandom_range(0, 1) == 1;
      dest_idx    = AW'($urandom_range(0, NUM_AR - 1));
      T_in        = PW'($urandom_range(0, NUM_PR - 1));
      rs1_idx     = AW'($urandom_range(0, NUM_AR - 1));
      rs2_idx     = AW'($urandom_range(0, NUM_AR - 1));
      cdb_en      = $urandom_range(0, 1) == 1;
      cdb_T       = ($urandom_range(0, 1) == 1) ? PW'(m_tag[$urandom_range(0, NUM_AR - 1)])
                                                : PW'($urandom_range(0, NUM_PR - 1));
      rollback_en = ($urandom_range(0, 19) == 0);
      for (int i = 0; i < NUM_AR; i++)
        rollback_map[i*PW +: PW] = PW'($urandom_range(0, NUM_PR - 1));
      #1;
      check_all($sformatf("rnd%0d", n));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
